sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

SPI-mode SD card responder: the card side of the SPI link driven by the team's SD card controller. It decodes CMD0, CMD55, ACMD41, CMD17 and CMD24 from the host, returns R1, data tokens and data responses, and backs block data with an external byte-wide synchronous RAM. It is used as a card model in system simulation and as an FPGA-hosted card emulator.

## Interface
- MEM_AW, 16: RAM byte-address width. Card capacity is 2^MEM_AW bytes.
- INIT_POLLS, 3: ACMD41 count that returns R1=0x01 before the first ACMD41 that returns 0x00.
- NAC_BYTES, 2: number of 0xFF bytes between the CMD17 R1 and the 0xFE start token.
- BUSY_BYTES, 4: number of 0x00 busy bytes after the write data response.
- clk  in  1  system clock; frequency at least 8× the sclk frequency.
- reset  in  1  synchronous, active-high.
- cs  in  1  host chip select, active low, asynchronous to clk.
- sclk  in  1  host SPI clock, asynchronous to clk.
- mosi  in  1  host-to-card data.
- miso  out  1  card-to-host data. Reads 1 whenever there is nothing to send.
- mem_addr  out  MEM_AW  RAM byte address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid on the next clk.
- mem_rdata  in  8  RAM read data.
- mem_wr_en  out  1  single-cycle write strobe.
- mem_wdata  out  8  RAM write data.
- initialized  out  1  high once ACMD41 has returned 0x00.

## Operation
- cs, sclk and mosi pass through 2-FF synchronizers. Rise and fall events are detected from the synchronized sclk.
- SPI mode 0:
  - mosi is sampled on the sclk rise event.
  - miso changes only on the sclk fall event.
- Byte framing:
  - The bit counter clears on the cs fall event.
  - A byte completes on its 8th rise.
  - The next transmit byte loads into tx_sr on the fall event that follows. miso = tx_sr[7].
- States: CS_HIGH, CMD_RX, NCR, R1, RD_NAC, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY.
- CS_HIGH: miso=1. The cs fall event moves to CMD_RX.
- CMD_RX: transmits 0xFF.
  - A received byte with [7:6]=01 starts a command.
  - The 5 bytes that follow are collected as arg[31:0] and crc. crc is ignored.
  - After the 6th byte, go to NCR.
- NCR: transmits one 0xFF byte, then goes to R1.
- R1 value; idle = 1 until initialized.
  - CMD0: 0x01. Clears initialized, app flag and poll count.
  - CMD55: {7'b0, idle}. Sets the app flag.
  - CMD41 with the app flag set:
    - While poll count < INIT_POLLS: return 0x01 and increment the count.
    - Otherwise: return 0x00 and set initialized.
  - CMD41 without the app flag: illegal command.
  - The app flag clears after any command other than CMD55.
  - CMD17 or CMD24 while idle: 0x05.
  - CMD17 or CMD24 with arg[8:0]≠0: 0x20 (address error).
  - CMD17 or CMD24 with arg[31:MEM_AW]≠0: 0x40 (parameter error). The address check takes priority over this check.
  - Any other command: 0x04 | idle.
- After R1:
  - CMD17 with R1=0x00 goes to RD_NAC.
  - CMD24 with R1=0x00 goes to WR_TOKEN.
  - Every other case returns to CMD_RX.
- Read path:
  - RD_NAC: NAC_BYTES × 0xFF.
  - RD_TOKEN: 0xFE.
  - RD_DATA: 512 bytes from RAM at arg[MEM_AW-1:0]+i.
  - RD_CRC: 0xFF, 0xFF. CRC is not computed.
  - Then CMD_RX.
  - Each byte is prefetched with mem_rd_en in the clk after the previous byte's load event.
- Write path:
  - WR_TOKEN: transmits 0xFF. Discards received bytes until 0xFE arrives.
  - WR_DATA: 512 received bytes. Each is written with one mem_wr_en pulse, at address arg+i, in the clk after the byte completes.
  - WR_CRC: 2 bytes received and discarded.
  - WR_DRESP: transmits 0xE5 (data accepted).
  - WR_BUSY: transmits BUSY_BYTES × 0x00.
  - Then CMD_RX, which transmits 0xFF.
- A cs rise event in any state goes to CS_HIGH and forces miso=1.
  - Bytes already written to RAM remain written.
  - initialized and the app flag are kept.
- Address arithmetic is modulo 2^MEM_AW. The range check guarantees a block never wraps.

## Timing
- Reset values:
  - miso=1, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, initialized=0.
  - State CS_HIGH, poll count 0, app flag 0.
- miso settles ≤4 clk after the sclk fall edge: 2 synchronizer stages, 1 edge detect, 1 register.
- mem_wr_en is high for exactly 1 clk per data byte, with mem_addr and mem_wdata valid in that clk.
- mem_rd_en is high for exactly 1 clk per data byte. At most one read is outstanding.
- With cs held low and the host clocking continuously, R1 occupies byte slot 8 after the command start byte. The start byte is slot 0, the argument and crc are slots 1-5, and NCR is slot 6.
- Rise and fall events arriving in the same clk cannot occur when the clock ratio is ≥8.

## Test plan
- Host sends FF,40 00000000 95 -> NCR 0xFF, then R1=0x01; initialized=0.
- CMD55/ACMD41 loop with INIT_POLLS=3 -> ACMD41 R1 values 01,01,01,00; initialized rises after the 4th.
- RAM preloaded with byte i at 0x200+i; CMD17 arg 0x00000200 -> R1 00, FF,FF, FE, bytes 00..FF,00..FF, FF,FF; 512 mem_rd_en pulses.
- CMD24 arg 0x00000400, token FE, data i^0x5A, CRC 0000 -> R1 00; 512 mem_wr_en pulses at 0x400..0x5FF; response E5, then four 00 bytes, then FF.
- CMD17 arg 0x00000201 -> R1 20; CMD17 arg 0x00010000 -> R1 40; no mem_rd_en.
- cs raised after 100 CMD24 data bytes -> miso=1 within 4 clk; exactly 100 writes; next CMD0 returns 0x01.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder (card side). Decodes CMD0/CMD55/ACMD41/CMD17/CMD24,
// returns R1, read data blocks and write data responses, and stores block data
// in an external byte-wide synchronous RAM.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cs, sclk, mosi      host SPI inputs (asynchronous to clk, mode 0)
//   miso                card-to-host data, 1 when idle
//   mem_addr/mem_rd_en/mem_rdata/mem_wr_en/mem_wdata  RAM port (1-clk read latency)
//   initialized         high once ACMD41 has returned 0x00
module sd_spi_responder #(
  parameter int MEM_AW     = 16,
  parameter int INIT_POLLS = 3,
  parameter int NAC_BYTES  = 2,
  parameter int BUSY_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic              initialized
);
  typedef enum logic [3:0] {
    CS_HIGH, CMD_RX, NCR, R1, RD_NAC, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
  } state_t;
  state_t state, state_nx;

  logic [1:0] cs_s, sclk_s, mosi_s;
  logic       cs_q, sclk_q;
  logic       cs_rise, cs_fall, cs_low, rise, fall, ld;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_next, rx_byte, tx_sr, tx_next, r1_val, rd_buf;
  logic       pending, rd_q, app, idle, rd_go;
  logic [9:0] byte_idx, idx_nx, rd_idx;
  logic [5:0] cmd;
  logic [31:0] arg;
  logic [7:0] polls;
  logic [MEM_AW-1:0] base;

  assign cs_rise = cs_s[1] & ~cs_q;
  assign cs_fall = ~cs_s[1] & cs_q;
  // SPI events only count once cs has been low for a full clk, so they never
  // coincide with the cs fall that re-arms the byte framing.
  assign cs_low  = ~cs_s[1] & ~cs_q;
  assign rise    = cs_low & sclk_s[1] & ~sclk_q;
  assign fall    = cs_low & ~sclk_s[1] & sclk_q;
  assign rx_next = {rx_sr, mosi_s[1]};
  // A completed byte is acted on at the following fall: the byte for the
  // current state is loaded first, then the state advances.
  assign ld      = fall & pending;
  assign idle    = ~initialized;
  assign base    = arg[MEM_AW-1:0];
  assign miso    = (state == CS_HIGH) ? 1'b1 : tx_sr[7];

  always_comb begin
    r1_val = {5'b0, 1'b1, 1'b0, idle};
    case (cmd)
      6'd0:  r1_val = 8'h01;
      6'd55: r1_val = {7'b0, idle};
      6'd41: if (app) r1_val = (int'(polls) < INIT_POLLS) ? 8'h01 : 8'h00;
      6'd17, 6'd24: begin
        if (idle)                       r1_val = 8'h05;
        else if (arg[8:0] != 9'd0)      r1_val = 8'h20;
        else if ((arg >> MEM_AW) != 0)  r1_val = 8'h40;
        else                            r1_val = 8'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    idx_nx   = byte_idx;
    tx_next  = 8'hFF;
    rd_go    = 1'b0;
    rd_idx   = byte_idx + 10'd1;
    if (cs_rise) begin
      state_nx = CS_HIGH;
    end else if (cs_fall) begin
      state_nx = CMD_RX;
      idx_nx   = 10'd0;
    end else if (ld) begin
      idx_nx = byte_idx + 10'd1;
      case (state)
        CMD_RX: begin
          if (byte_idx == 10'd0)
            idx_nx = (rx_byte[7:6] == 2'b01) ? 10'd1 : 10'd0;
          else if (byte_idx == 10'd5) begin
            state_nx = NCR; idx_nx = 10'd0;
          end
        end
        NCR: begin state_nx = R1; idx_nx = 10'd0; end
        R1: begin
          tx_next = r1_val;
          idx_nx  = 10'd0;
          if (r1_val == 8'h00 && cmd == 6'd17)      state_nx = RD_NAC;
          else if (r1_val == 8'h00 && cmd == 6'd24) state_nx = WR_TOKEN;
          else                                      state_nx = CMD_RX;
        end
        RD_NAC:
          if (byte_idx == 10'(NAC_BYTES - 1)) begin state_nx = RD_TOKEN; idx_nx = 10'd0; end
        RD_TOKEN: begin
          tx_next = 8'hFE; state_nx = RD_DATA; idx_nx = 10'd0;
          rd_go = 1'b1; rd_idx = 10'd0;
        end
        RD_DATA: begin
          tx_next = rd_buf;
          rd_go   = (byte_idx != 10'd511);
          if (byte_idx == 10'd511) begin state_nx = RD_CRC; idx_nx = 10'd0; end
        end
        RD_CRC:
          if (byte_idx == 10'd1) begin state_nx = CMD_RX; idx_nx = 10'd0; end
        WR_TOKEN: begin
          idx_nx = 10'd0;
          if (rx_byte == 8'hFE) state_nx = WR_DATA;
        end
        WR_DATA:
          if (byte_idx == 10'd511) begin state_nx = WR_CRC; idx_nx = 10'd0; end
        WR_CRC:
          if (byte_idx == 10'd1) begin state_nx = WR_DRESP; idx_nx = 10'd0; end
        WR_DRESP: begin tx_next = 8'hE5; state_nx = WR_BUSY; idx_nx = 10'd0; end
        WR_BUSY: begin
          tx_next = 8'h00;
          if (byte_idx == 10'(BUSY_BYTES - 1)) begin state_nx = CMD_RX; idx_nx = 10'd0; end
        end
        default: idx_nx = byte_idx;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s <= 2'b11; cs_q <= 1'b1; sclk_s <= 2'b00; sclk_q <= 1'b0; mosi_s <= 2'b00;
      state <= CS_HIGH; byte_idx <= 10'd0; bit_cnt <= 3'd0; rx_sr <= 7'd0;
      rx_byte <= 8'd0; pending <= 1'b0; tx_sr <= 8'hFF; cmd <= 6'd0; arg <= 32'd0;
      app <= 1'b0; polls <= 8'd0; initialized <= 1'b0; rd_buf <= 8'hFF; rd_q <= 1'b0;
      mem_addr <= '0; mem_rd_en <= 1'b0; mem_wr_en <= 1'b0; mem_wdata <= 8'd0;
    end else begin
      cs_s   <= {cs_s[0], cs};
      cs_q   <= cs_s[1];
      sclk_s <= {sclk_s[0], sclk};
      sclk_q <= sclk_s[1];
      mosi_s <= {mosi_s[0], mosi};
      state    <= state_nx;
      byte_idx <= idx_nx;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      rd_q      <= mem_rd_en;
      if (rd_q) rd_buf <= mem_rdata;
      if (cs_fall) begin
        bit_cnt <= 3'd0; pending <= 1'b0; tx_sr <= 8'hFF;
      end
      if (rise) begin
        rx_sr   <= rx_next[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= rx_next;
          pending <= 1'b1;
          if (state == WR_DATA) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= base + MEM_AW'(byte_idx);
            mem_wdata <= rx_next;
          end
        end
      end
      if (fall) begin
        if (pending) begin
          tx_sr   <= tx_next;
          pending <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
      if (ld) begin
        case (state)
          CMD_RX:
            if (byte_idx == 10'd0)     cmd <= rx_byte[5:0];
            else if (byte_idx < 10'd5) arg <= {arg[23:0], rx_byte};
          R1: begin
            app <= (cmd == 6'd55);
            if (cmd == 6'd0) begin
              initialized <= 1'b0; polls <= 8'd0;
            end else if (cmd == 6'd41 && app) begin
              if (int'(polls) < INIT_POLLS) polls <= polls + 8'd1;
              else                          initialized <= 1'b1;
            end
          end
          default: ;
        endcase
        if (rd_go) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= base + MEM_AW'(rd_idx);
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps
module tb_sd_spi_responder;
  localparam int HP = 4;  // clk per sclk half period (ratio 8)

  logic clk = 1'b0, reset, cs, sclk, mosi, miso;
  logic [15:0] mem_addr;
  logic mem_rd_en, mem_wr_en, initialized;
  logic [7:0] mem_rdata = 8'h00, mem_wdata;
  logic [7:0] mem [0:65535] = '{default: 8'h00};

  int tests = 0, fails = 0;
  int rd_cnt = 0, wr_cnt = 0, wr_bad = 0, dbl = 0, wr_start = 0;
  logic [15:0] wr_base = 16'h0;
  logic rd_prev = 1'b0, wr_prev = 1'b0;

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .initialized(initialized)
  );

  // RAM model plus strobe monitor
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[16'h200 + 16'(i)] <= 8'(i);
    end
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt = rd_cnt + 1;
    end
    if (mem_wr_en) begin
      if (mem_addr !== wr_base + 16'(wr_cnt - wr_start) ||
          mem_wdata !== (8'(wr_cnt - wr_start) ^ 8'h5A)) wr_bad = wr_bad + 1;
      mem[mem_addr] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if ((mem_rd_en && rd_prev) || (mem_wr_en && wr_prev)) dbl = dbl + 1;
    rd_prev = mem_rd_en;
    wr_prev = mem_wr_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = t[i];
      repeat (HP) @(negedge clk);
      r[i] = miso;
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] a,
                          output logic [7:0] ncr, output logic [7:0] r1);
    logic [7:0] d, b6, b7;
    spi_byte({2'b01, c}, d);
    for (int i = 3; i >= 0; i--) spi_byte(a[i*8 +: 8], d);
    spi_byte((c == 6'd0) ? 8'h95 : 8'h01, d);
    spi_byte(8'hFF, b6);
    spi_byte(8'hFF, b7);
    spi_byte(8'hFF, r1);
    ncr = b6 & b7;
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic        init;
  } vec_t;
  vec_t v [15];

  initial begin
    logic [7:0] d, d2, ncr, r1;
    int bad, rd0, found;
    v[0]  = '{6'd0,  32'h0,     8'h01, 1'b0};
    v[1]  = '{6'd17, 32'h200,   8'h05, 1'b0};
    v[2]  = '{6'd55, 32'h0,     8'h01, 1'b0};
    v[3]  = '{6'd41, 32'h0,     8'h01, 1'b0};
    v[4]  = '{6'd55, 32'h0,     8'h01, 1'b0};
    v[5]  = '{6'd41, 32'h0,     8'h01, 1'b0};
    v[6]  = '{6'd55, 32'h0,     8'h01, 1'b0};
    v[7]  = '{6'd41, 32'h0,     8'h01, 1'b0};
    v[8]  = '{6'd55, 32'h0,     8'h01, 1'b0};
    v[9]  = '{6'd41, 32'h0,     8'h00, 1'b1};
    v[10] = '{6'd55, 32'h0,     8'h00, 1'b1};
    v[11] = '{6'd17, 32'h201,   8'h20, 1'b1};
    v[12] = '{6'd17, 32'h10000, 8'h40, 1'b1};
    v[13] = '{6'd41, 32'h0,     8'h04, 1'b1};
    v[14] = '{6'd24, 32'h10201, 8'h20, 1'b1};

    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    repeat (3) @(negedge clk);
    check("reset miso", miso, 1);
    check("reset rd_en", mem_rd_en, 0);
    check("reset wr_en", mem_wr_en, 0);
    check("reset addr", mem_addr, 0);
    check("reset wdata", mem_wdata, 0);
    check("reset init", initialized, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(8'hFF, d);
    check("idle byte", d, 8'hFF);

    for (int k = 0; k < 15; k++) begin
      send_cmd(v[k].cmd, v[k].arg, ncr, r1);
      check($sformatf("vec%0d ncr", k), ncr, 8'hFF);
      check($sformatf("vec%0d r1", k), r1, v[k].r1);
      check($sformatf("vec%0d init", k), initialized, v[k].init);
    end
    check("no reads from rejected cmds", rd_cnt, 0);
    check("no writes from rejected cmds", wr_cnt, 0);

    // Block read
    rd0 = rd_cnt;
    send_cmd(6'd17, 32'h200, ncr, r1);
    check("cmd17 r1", r1, 8'h00);
    spi_byte(8'hFF, d); spi_byte(8'hFF, d2);
    check("read nac", {d, d2}, 16'hFFFF);
    spi_byte(8'hFF, d);
    check("read token", d, 8'hFE);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      spi_byte(8'hFF, d);
      if (d !== 8'(i)) bad++;
    end
    check("read data errors", bad, 0);
    spi_byte(8'hFF, d); spi_byte(8'hFF, d2);
    check("read crc", {d, d2}, 16'hFFFF);
    spi_byte(8'hFF, d);
    check("after read", d, 8'hFF);
    check("read strobes", rd_cnt - rd0, 512);

    // Block write
    wr_base = 16'h400; wr_start = wr_cnt;
    send_cmd(6'd24, 32'h400, ncr, r1);
    check("cmd24 r1", r1, 8'h00);
    spi_byte(8'hFF, d);
    spi_byte(8'hFE, d);
    for (int i = 0; i < 512; i++) spi_byte(8'(i) ^ 8'h5A, d);
    spi_byte(8'h00, d); spi_byte(8'h00, d);
    found = 0;
    for (int j = 0; j < 8 && found == 0; j++) begin
      spi_byte(8'hFF, d);
      if (d == 8'hE5) found = 1;
    end
    check("data response", found, 1);
    for (int j = 0; j < 4; j++) begin
      spi_byte(8'hFF, d);
      check($sformatf("busy%0d", j), d, 8'h00);
    end
    spi_byte(8'hFF, d);
    check("after busy", d, 8'hFF);
    check("write strobes", wr_cnt - wr_start, 512);
    check("write addr/data errors", wr_bad, 0);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[16'h400 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
    check("ram contents", bad, 0);
    check("strobe width", dbl, 0);

    // cs abort during read data: miso must be forced high
    send_cmd(6'd17, 32'h200, ncr, r1);
    check("cmd17 again r1", r1, 8'h00);
    spi_byte(8'hFF, d); spi_byte(8'hFF, d); spi_byte(8'hFF, d);
    repeat (4) @(negedge clk);
    check("read byte0 msb", miso, 0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check("miso forced high", miso, 1);
    cs = 1'b0;
    repeat (6) @(negedge clk);

    // cs abort after 100 write bytes
    wr_base = 16'h800; wr_start = wr_cnt;
    send_cmd(6'd24, 32'h800, ncr, r1);
    check("cmd24 abort r1", r1, 8'h00);
    spi_byte(8'hFE, d);
    for (int i = 0; i < 100; i++) spi_byte(8'(i) ^ 8'h5A, d);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check("abort miso", miso, 1);
    repeat (4) @(negedge clk);
    check("abort writes", wr_cnt - wr_start, 100);
    check("abort addr/data errors", wr_bad, 0);
    check("abort byte 100 untouched", mem[16'h800 + 16'd100], 8'h00);
    check("init kept", initialized, 1);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    send_cmd(6'd0, 32'h0, ncr, r1);
    check("cmd0 after abort", r1, 8'h01);
    check("init cleared", initialized, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
